// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over an sram-like handshake and
// buffers returned {pc, inst} pairs for decode. Redirects flush and cancel in-flight fetches.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   rq_pc   [DEPTH];
  logic [31:0]   ib_pc   [DEPTH];
  logic [31:0]   ib_inst [DEPTH];
  logic [PW-1:0] rq_wr, rq_rd, ib_wr, ib_rd;
  logic [CW-1:0] out_cnt, buf_cnt, cancel_cnt;

  logic issue, resp, drop, pop;
  logic unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign inst_req  = cpu_rstn && !redirect_valid && ((out_cnt + buf_cnt + cancel_cnt) < DEPTH_C);
  assign inst_addr = pc;
  assign id_valid  = (buf_cnt != '0);
  assign id_pc     = ib_pc[ib_rd];
  assign id_inst   = ib_inst[ib_rd];

  assign issue = inst_req && inst_addr_ok;
  assign resp  = inst_data_ok && (cancel_cnt == '0);
  assign drop  = inst_data_ok && (cancel_cnt != '0);
  assign pop   = id_valid && id_ready;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      pc         <= RESET_PC;
      rq_wr      <= '0;
      rq_rd      <= '0;
      ib_wr      <= '0;
      ib_rd      <= '0;
      out_cnt    <= '0;
      buf_cnt    <= '0;
      cancel_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rq_pc[i]   <= '0;
        ib_pc[i]   <= '0;
        ib_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc      <= {redirect_pc[31:2], 2'b00};
      rq_wr   <= '0;
      rq_rd   <= '0;
      ib_wr   <= '0;
      ib_rd   <= '0;
      out_cnt <= '0;
      buf_cnt <= '0;
      // Any response this cycle retires one outstanding slot, live or already cancelled.
      cancel_cnt <= cancel_cnt + out_cnt - CW'(inst_data_ok);
    end else begin
      if (issue) begin
        rq_pc[rq_wr] <= pc;
        rq_wr        <= rq_wr + PW'(1);
        pc           <= pc + 32'd4;
      end
      if (resp) begin
        ib_pc[ib_wr]   <= rq_pc[rq_rd];
        ib_inst[ib_wr] <= inst_rdata;
        ib_wr          <= ib_wr + PW'(1);
        rq_rd          <= rq_rd + PW'(1);
      end
      if (pop) begin
        ib_rd <= ib_rd + PW'(1);
      end
      if (drop) begin
        cancel_cnt <= cancel_cnt - CW'(1);
      end
      case ({issue, resp})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
      case ({resp, pop})
        2'b10:   buf_cnt <= buf_cnt + CW'(1);
        2'b01:   buf_cnt <= buf_cnt - CW'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory side broke the protocol.
  a_no_orphan_resp: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    !(inst_data_ok && (out_cnt == '0) && (cancel_cnt == '0)));
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: 1-cycle memory model plus an in-order scoreboard on the decode side.
module tb_if_fetch_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] pend  [$];
  logic        mem_hold = 1'b0;
  int          acc_cnt  = 0;

  if_fetch_stage #(
    .RESET_PC (32'h1C00_0000),
    .DEPTH    (2)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rstn       (cpu_rstn),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    id_ready = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge cpu_clk);
      n++;
    end
    id_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s left=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory: accepts every request, answers in order one cycle later unless held.
  initial begin
    logic        acc, rsp;
    logic [31:0] acc_addr;
    forever begin
      @(negedge cpu_clk);
      #1;
      if (!cpu_rstn) pend.delete();
      inst_data_ok = (pend.size() != 0) && !mem_hold;
      inst_rdata   = inst_data_ok ? mem_word(pend[0]) : 32'hDEAD_BEEF;
      #2;
      acc      = inst_req && inst_addr_ok;
      acc_addr = inst_addr;
      rsp      = inst_data_ok;
      @(posedge cpu_clk);
      if (!cpu_rstn) begin
        pend.delete();
      end else begin
        if (rsp) void'(pend.pop_front());
        if (acc) begin
          pend.push_back(acc_addr);
          acc_cnt++;
        end
      end
    end
  end

  // Scoreboard monitor: every decode handshake must match the next expected entry.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge cpu_clk);
      #3;
      if (cpu_rstn && id_valid && id_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra got pc=%h inst=%h want none", id_pc, id_inst);
        end else begin
          e = exp_q.pop_front();
          if (id_pc !== e || id_inst !== mem_word(e)) begin
            errors++;
            $display("FAIL sb_entry got pc=%h inst=%h want pc=%h inst=%h",
                     id_pc, id_inst, e, mem_word(e));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpu_rstn       = 1'b0;
    inst_addr_ok   = 1'b1;
    inst_data_ok   = 1'b0;
    inst_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    cyc(3);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_inst_req", 32'(inst_req), 32'd0);

    // Back-pressure: only two fetches fit, then drain and resume at 1C000008.
    cpu_rstn = 1'b1;
    cyc(10);
    chk("full_inst_req", 32'(inst_req), 32'd0);
    chk("full_acc_cnt", 32'(acc_cnt), 32'd2);
    chk("full_id_valid", 32'(id_valid), 32'd1);
    chk("full_id_pc", id_pc, 32'h1C00_0000);
    chk("full_inst_addr", inst_addr, 32'h1C00_0008);
    push_seq(32'h1C00_0000, 8);
    drain("drain_seq", 100);

    // Async reset with a full buffer; memory held so two fetches stay outstanding.
    cyc(4);
    chk("pre_rst_id_valid", 32'(id_valid), 32'd1);
    mem_hold = 1'b1;
    cpu_rstn = 1'b0;
    #1;
    chk("async_id_valid", 32'(id_valid), 32'd0);
    chk("async_inst_req", 32'(inst_req), 32'd0);
    cyc(2);
    cpu_rstn = 1'b1;
    #1;
    chk("rel_inst_addr", inst_addr, 32'h1C00_0000);
    cyc(5);
    chk("out2_inst_req", 32'(inst_req), 32'd0);
    chk("out2_id_valid", 32'(id_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_0103;
    #1;
    chk("redir_inst_req", 32'(inst_req), 32'd0);
    cyc(1);
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    #1;
    chk("redir_inst_addr", inst_addr, 32'h1C00_0100);
    chk("redir_id_valid", 32'(id_valid), 32'd0);
    push_seq(32'h1C00_0100, 4);
    drain("drain_redir", 60);

    // Redirect lands in the same cycle as the response for 1C000000.
    cyc(1);
    cpu_rstn = 1'b0;
    cyc(2);
    cpu_rstn = 1'b1;
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_2000;
    #2;
    chk("same_cyc_inst_req", 32'(inst_req), 32'd0);
    cyc(1);
    redirect_valid = 1'b0;
    push_seq(32'h1C00_2000, 4);
    drain("drain_same_cyc", 60);

    // Back-to-back redirects to A then B with one fetch outstanding.
    cyc(1);
    cpu_rstn = 1'b0;
    mem_hold = 1'b1;
    cyc(2);
    cpu_rstn = 1'b1;
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_3000;
    cyc(1);
    redirect_pc    = 32'h1C00_4000;
    cyc(1);
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    #1;
    chk("b2b_inst_addr", inst_addr, 32'h1C00_4000);
    push_seq(32'h1C00_4000, 4);
    drain("drain_b2b", 60);

    // Redirect with a full buffer: id_valid must fall the following cycle.
    cyc(4);
    chk("flush_pre_id_valid", 32'(id_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C00_5000;
    cyc(1);
    redirect_valid = 1'b0;
    #1;
    chk("flush_id_valid", 32'(id_valid), 32'd0);
    push_seq(32'h1C00_5000, 2);
    drain("drain_flush", 60);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
